// File: rtl/ms_delay_timer_pkg.sv
// ms_delay_timer_pkg
//   Shared definitions for the millisecond delay timer and its users:
//   FSM state encoding, default duration width and the named delays the
//   game sequencer programs into the timer.
package ms_delay_timer_pkg;

  // Default width of duration / remaining (max delay 2^12-1 = 4095 ms).
  localparam int unsigned DUR_W_DEF = 12;

  // Delay timer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Sequencer delays in milliseconds.
  localparam int unsigned LED_ON_MS  = 500;
  localparam int unsigned LED_OFF_MS = 250;
  localparam int unsigned GAP_MS     = 100;
  localparam int unsigned RESP_MS    = 2000;

endpackage

// File: rtl/ms_tick_qual.sv
// ms_tick_qual
//   Qualifies the timeout pulse of the millisecond tick generator.
//   The generator holds its timeout high while its enable is low, so the
//   first enabled cycle may show a stale high. A tick is only counted when
//   the enable was already high in the previous cycle.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   tick_en  enable currently driven to the generator
//   ms_tick  timeout output of the generator
//   tick     counted-tick strobe (ms_tick qualified by delayed enable)
module ms_tick_qual (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic ms_tick,
  output logic tick
);

  logic tick_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_en_q <= 1'b0;
    end else begin
      tick_en_q <= tick_en;
    end
  end

  assign tick = ms_tick & tick_en_q;

endmodule

// File: rtl/ms_delay_timer.sv
// ms_delay_timer
//   Counts a programmed number of millisecond ticks and pulses done on
//   completion. Drives the enable of the millisecond tick generator and
//   consumes its timeout. Supports start, level pause and abort.
//   All outputs are decoded from registered state / registered count.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      begin a delay of duration ms (accepted in IDLE only)
//   duration   delay length in ms, captured on accepted start
//   pause      level; suspends tick counting while high in RUN/PAUSED
//   abort      cancel delay, return to IDLE without done
//   ms_tick    timeout output of the millisecond tick generator
//   tick_en    enable to the millisecond tick generator (high in RUN)
//   busy       high in RUN or PAUSED
//   done       one-cycle completion pulse
//   remaining  ms still to count; 0 when idle
module ms_delay_timer
  import ms_delay_timer_pkg::*;
#(
  parameter int unsigned DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DUR_W-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  input  logic             ms_tick,
  output logic             tick_en,
  output logic             busy,
  output logic             done,
  output logic [DUR_W-1:0] remaining
);

  state_t           state, state_n;
  logic [DUR_W-1:0] rem, rem_n;
  logic             tick;

  ms_tick_qual u_tick_qual (
    .clk     (clk),
    .rst     (rst),
    .tick_en (tick_en),
    .ms_tick (ms_tick),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  // Priority in RUN/PAUSED: abort > completion > pause. A tick counted in
  // the cycle pause rises still decrements.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (duration == '0) begin
            state_n = DONE;
          end else begin
            rem_n   = duration;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          rem_n   = '0;
          state_n = IDLE;
        end else if (tick && (rem == DUR_W'(1))) begin
          rem_n   = '0;
          state_n = DONE;
        end else begin
          if (tick) begin
            rem_n = rem - DUR_W'(1);
          end
          if (pause) begin
            state_n = PAUSED;
          end
        end
      end
      PAUSED: begin
        if (abort) begin
          rem_n   = '0;
          state_n = IDLE;
        end else if (!pause) begin
          state_n = RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        rem_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign tick_en   = (state == RUN);
  assign busy      = (state == RUN) || (state == PAUSED);
  assign done      = (state == DONE);
  assign remaining = rem;

endmodule

// File: tb/tb_ms_delay_timer.sv
// tb_ms_delay_timer
//   Scoreboard bench for ms_delay_timer. Stimulus pushes the expected
//   completion (tick count, latency reference) per delay; a monitor counts
//   qualified ticks on the pins and pops/compares on every done pulse.
//   A behavioural tick generator pulses ms_tick every 10 enabled cycles and
//   holds its output while disabled.
module tb_ms_delay_timer;
  import ms_delay_timer_pkg::*;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] duration;
  logic          pause;
  logic          abort;
  logic          ms_tick;
  logic          tick_en;
  logic          busy;
  logic          done;
  logic [DW-1:0] remaining;

  always #5 clk = ~clk;

  ms_delay_timer #(.DUR_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .duration  (duration),
    .pause     (pause),
    .abort     (abort),
    .ms_tick   (ms_tick),
    .tick_en   (tick_en),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  // Tick generator model: free-running while enabled, output frozen while
  // disabled. force_stale lets the bench present a stale high in IDLE.
  logic        mt = 1'b0;
  int unsigned mcnt = 0;
  logic        force_stale = 1'b0;
  assign ms_tick = mt | force_stale;

  always @(posedge clk) begin
    if (tick_en) begin
      if (mcnt == 9) begin
        mcnt <= 0;
        mt   <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
        mt   <= 1'b0;
      end
    end
  end

  // Bench's own view of the delayed enable and a cycle counter.
  logic        tbq = 1'b0;
  int unsigned cyc = 0;
  always @(posedge clk) begin
    tbq <= tick_en;
    cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned ticks;
    bit          zero;
    int unsigned start_cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: counts qualified ticks during a delay, checks on each done.
  int unsigned mon_cnt = 0;
  int unsigned last_tick_cyc = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_ticks", mon_cnt, e.ticks);
          // done is high in the cycle right after the start cycle (dur 0)
          // or right after the cycle of the final counted tick.
          if (e.zero) check("dur0_latency", cyc - e.start_cyc, 32'd1);
          else        check("done_latency", cyc - last_tick_cyc, 32'd1);
        end
        mon_cnt = 0;
      end else if (!busy) begin
        mon_cnt = 0;
      end
      if (busy && ms_tick && tbq) begin
        mon_cnt++;
        last_tick_cyc = cyc;
      end
    end
  end

  // Issue a start at the current negedge; returns one cycle later.
  task automatic issue(input int unsigned dur, input bit expect_done);
    exp_t e;
    start    = 1'b1;
    duration = DW'(dur);
    if (expect_done) begin
      e.ticks     = dur;
      e.zero      = (dur == 0);
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50000; i++) begin
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_counted(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && ms_tick && tbq) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rem(input logic [DW-1:0] v, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy && remaining == v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : stim
    bit ok;
    bit te_seen;
    exp_t e;
    rst = 1'b1; start = 1'b0; duration = '0; pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tick_en", tick_en, 1'b0);
    check("rst_remaining", remaining, '0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-RUN with remaining=5.
    issue(8, 1'b0);
    wait_rem(DW'(5), "rst_mid");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_tick_en", tick_en, 1'b0);
    check("midrst_remaining", remaining, '0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);

    // duration=3: remaining 3 -> 2 -> 1 -> 0.
    issue(3, 1'b1);
    check("d3_busy", busy, 1'b1);
    check("d3_rem_start", remaining, 32'd3);
    for (int k = 2; k >= 0; k--) begin
      wait_counted("d3_tick");
      @(negedge clk);
      check("d3_rem_step", remaining, k);
    end
    wait_idle("d3");

    // Stale tick held high in IDLE must not count on the first RUN cycle.
    force_stale = 1'b1;
    @(negedge clk);
    issue(2, 1'b1);
    check("stale_rem_first", remaining, 32'd2);
    @(posedge clk);
    #1 force_stale = 1'b0;
    @(negedge clk);
    check("stale_ignored", remaining, 32'd2);
    wait_idle("stale");

    // Pause after 2 ticks for 50 cycles.
    issue(4, 1'b1);
    wait_rem(DW'(2), "pause_pre");
    pause = 1'b1;
    @(negedge clk);
    ok = 1'b1;
    repeat (50) begin
      if (tick_en !== 1'b0 || remaining !== DW'(2) || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("pause_hold", ok, 1'b1);
    pause = 1'b0;
    wait_idle("pause");
    check("pause_end_rem", remaining, '0);

    // Abort on the cycle of the final tick.
    issue(2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && ms_tick && tbq && remaining == DW'(1)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("abort_wait_timeout", 32'd0, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_rem", remaining, '0);
    check("abort_done", done, 1'b0);
    repeat (3) @(negedge clk);
    issue(1, 1'b1);
    wait_idle("after_abort");

    // duration=0: done next cycle, tick_en never high.
    te_seen = 1'b0;
    issue(0, 1'b1);
    repeat (3) begin
      if (tick_en) te_seen = 1'b1;
      @(negedge clk);
    end
    check("dur0_no_tick_en", te_seen, 1'b0);
    wait_idle("dur0");

    // start held high through DONE: ignored there, accepted next cycle.
    start    = 1'b1;
    duration = '0;
    e.ticks = 0; e.zero = 1'b1; e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    check("held_start_gap", done, 1'b0);
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle("held_start");

    // Maximum duration.
    issue(4095, 1'b1);
    wait_idle("dmax");

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
